// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer among NREQ byte producers.
// It has a watchdog on the serializer's done and a programmable idle gap between frames.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int ID_W       = 2,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [ID_W-1:0]   grant_id,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy,
  output logic              err_timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  // A frame that ends with no idle gap goes straight back to arbitration.
  localparam logic [1:0] S_AFTER = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
  localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic            sel_found;
  logic [ID_W-1:0] sel_id;
  logic [NREQ-1:0] sel_onehot;
  logic [7:0]      sel_byte;

  // Search for the first active request at ptr, ptr+1, ... with wrap-around.
  always_comb begin
    sel_found  = 1'b0;
    sel_id     = '0;
    sel_onehot = '0;
    sel_byte   = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!sel_found && (j == (int'(ptr_q) + i) % NREQ) && req[j]) begin
          sel_found     = 1'b1;
          sel_id        = ID_W'(j);
          sel_onehot[j] = 1'b1;
          sel_byte      = req_data[8*j +: 8];
        end
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default value first, so no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    gnt_d      = '0;
    tx_start_d = 1'b0;
    err_d      = 1'b0;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d    = S_SEND;
          grant_id_d = sel_id;
          tx_data_d  = sel_byte;
          gnt_d      = sel_onehot;
          tx_start_d = 1'b1;
        end
      end
      S_SEND: begin
        state_d = S_WAIT;
        cnt_d   = '0;
        ptr_d   = (grant_id_q == ID_W'(NREQ - 1)) ? '0 : grant_id_q + ID_W'(1);
      end
      S_WAIT: begin
        // tx_done is tested first, so a done that arrives on the timeout edge still completes the frame.
        if (tx_done) begin
          state_d = S_AFTER;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_AFTER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so that every flop samples values from before the edge.
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign gnt         = gnt_q;
  assign grant_id    = grant_id_q;
  assign tx_data     = tx_data_q;
  assign tx_start    = tx_start_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. A transaction-level round-robin model predicts each grant.
// A second instance built with no idle gap covers back-to-back timing.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int GAP  = 2;
  localparam int TMO  = 64;
  localparam int ZTMO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  gnt;
  logic [1:0]  grant_id;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done = 1'b0;
  logic        busy;
  logic        err_timeout;

  logic [3:0]  z_req = '0;
  logic [31:0] z_req_data = '0;
  logic [3:0]  z_gnt;
  logic [1:0]  z_grant_id;
  logic [7:0]  z_tx_data;
  logic        z_tx_start;
  logic        z_tx_done = 1'b0;
  logic        z_busy;
  logic        z_err;

  logic [7:0]  exp_bytes [4];
  logic [3:0]  sticky = '0;
  int          model_ptr = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  uart_tx_arbiter #(.NREQ(4), .ID_W(2), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .grant_id(grant_id), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .busy(busy), .err_timeout(err_timeout));

  uart_tx_arbiter #(.NREQ(4), .ID_W(2), .GAP_CYCLES(0), .TIMEOUT(ZTMO)) dut_z (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .req(z_req), .req_data(z_req_data), .gnt(z_gnt),
    .grant_id(z_grant_id), .tx_data(z_tx_data), .tx_start(z_tx_start), .tx_done(z_tx_done),
    .busy(z_busy), .err_timeout(z_err));

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_byte(input int k, input logic [7:0] v);
    exp_bytes[k] = v;
    req_data[8*k +: 8] = v;
  endtask

  // The model lists the service order starting at the pointer and takes the first requester that is asserting.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    int order[$];
    int pick;
    pick = -1;
    for (int i = p; i < NREQ; i++) order.push_back(i);
    for (int i = 0; i < p; i++) order.push_back(i);
    foreach (order[j]) if (pick < 0 && ((r >> order[j]) & 4'b0001) != 4'b0000) pick = order[j];
    return pick;
  endfunction

  // One complete frame, starting from IDLE with requests already applied.
  // done_at is the edge after the grant at which tx_done is sampled; 0 means the serializer never answers.
  task automatic serve(input int done_at);
    int k, waited;
    logic [7:0] eb;
    logic [3:0] eg;
    k = rr_pick(req, model_ptr);
    if (k < 0) k = 0;
    eb = exp_bytes[k];
    eg = 4'b0001 << k;
    waited = 0;
    do begin tick(); waited++; end while (gnt === 4'b0000 && waited < 200);
    n_checks++; if (waited != 1) begin n_fail++; $display("FAIL grant_latency: got %0d cycles want 1", waited); end
    n_checks++; if (gnt !== eg || tx_start !== 1'b1) begin n_fail++; $display("FAIL grant: gnt=%b tx_start=%b want gnt=%b tx_start=1", gnt, tx_start, eg); end
    n_checks++; if (grant_id !== 2'(k) || tx_data !== eb || busy !== 1'b1) begin n_fail++; $display("FAIL grant_data: id=%0d data=%h busy=%b want id=%0d data=%h busy=1", grant_id, tx_data, busy, k, eb); end
    if (((sticky >> k) & 4'b0001) == 4'b0000) req = req & ~eg;
    model_ptr = (k + 1) % NREQ;
    tick();
    n_checks++; if (gnt !== 4'b0000 || tx_start !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL pulse_width: gnt=%b tx_start=%b busy=%b want 0000/0/1", gnt, tx_start, busy); end
    if (done_at >= 2) begin
      for (int c = 2; c < done_at; c++) begin
        n_checks++; if (err_timeout !== 1'b0 || tx_data !== eb || busy !== 1'b1) begin n_fail++; $display("FAIL wait_hold: err=%b data=%h busy=%b want 0/%h/1", err_timeout, tx_data, busy, eb); end
        tick();
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL done_no_err: err=%b want 0", err_timeout); end
    end else begin
      for (int c = 0; c < TMO; c++) begin
        n_checks++; if (err_timeout !== 1'b0 || tx_data !== eb) begin n_fail++; $display("FAIL early_err: cycle %0d err=%b data=%h want 0/%h", c, err_timeout, tx_data, eb); end
        tick();
      end
      n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse: err=%b want 1", err_timeout); end
    end
    for (int g = 0; g < GAP; g++) begin
      n_checks++; if (busy !== 1'b1 || gnt !== 4'b0000) begin n_fail++; $display("FAIL gap: cycle %0d busy=%b gnt=%b want 1/0000", g, busy, gnt); end
      tick();
    end
    n_checks++; if (busy !== 1'b0 || err_timeout !== 1'b0 || grant_id !== 2'(k)) begin n_fail++; $display("FAIL frame_end: busy=%b err=%b id=%0d want 0/0/%0d", busy, err_timeout, grant_id, k); end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    req = 4'b1111;
    tx_done = 1'b1;
    tick();
    tick();
    n_checks++; if (gnt !== 4'b0000 || tx_start !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_ctl: gnt=%b start=%b busy=%b err=%b want all 0", gnt, tx_start, busy, err_timeout); end
    n_checks++; if (grant_id !== 2'd0 || tx_data !== 8'h00 || z_busy !== 1'b0 || z_gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_data: id=%0d data=%h z_busy=%b z_gnt=%b want 0", grant_id, tx_data, z_busy, z_gnt); end
    req = '0;
    i_rst_n = 1'b1;
    model_ptr = 0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin n_fail++; $display("FAIL idle_stray_done: busy=%b gnt=%b want 0/0000", busy, gnt); end
  endtask

  task automatic test_all_requests();
    set_byte(0, 8'h11); set_byte(1, 8'h22); set_byte(2, 8'h33); set_byte(3, 8'h44);
    sticky = '0;
    req = 4'b1111;
    repeat (4) serve(int'($urandom_range(2, 20)));
    n_checks++; if (req !== 4'b0000 || model_ptr != 0) begin n_fail++; $display("FAIL all_served: req=%b ptr=%0d want 0000/0", req, model_ptr); end
  endtask

  task automatic test_single();
    set_byte(2, 8'h0B);
    req = 4'b0100;
    serve(10);
  endtask

  task automatic test_fairness();
    set_byte(0, 8'($urandom));
    set_byte(2, 8'($urandom));
    sticky = 4'b0101;
    req = 4'b0101;
    repeat (4) serve(int'($urandom_range(2, 12)));
    req = '0;
    sticky = '0;
  endtask

  task automatic test_timeout();
    set_byte(0, 8'($urandom));
    set_byte(1, 8'($urandom));
    req = 4'b0011;
    serve(0);
    serve(int'($urandom_range(2, 12)));
  endtask

  task automatic test_random();
    logic [3:0] nreq;
    for (int n = 0; n < 8; n++) begin
      nreq = 4'($urandom_range(1, 15));
      for (int k = 0; k < NREQ; k++)
        if (((nreq & ~req) >> k) & 4'b0001) set_byte(k, 8'($urandom));
      req = req | nreq;
      serve(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(2, 20)));
    end
    req = '0;
  endtask

  task automatic test_reset_mid_wait();
    set_byte(1, 8'($urandom));
    req = 4'b0010;
    tick();
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL mid_wait_grant: gnt=%b want 0010", gnt); end
    req = '0;
    tick();
    repeat (5) tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    model_ptr = 0;
    n_checks++; if (gnt !== 4'b0000 || tx_start !== 1'b0 || busy !== 1'b0 || err_timeout !== 1'b0 || grant_id !== 2'd0 || tx_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_mid_wait: gnt=%b start=%b busy=%b err=%b id=%0d data=%h want all 0", gnt, tx_start, busy, err_timeout, grant_id, tx_data); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || err_timeout !== 1'b0 || tx_start !== 1'b0) begin n_fail++; $display("FAIL late_done: busy=%b err=%b start=%b want 0", busy, err_timeout, tx_start); end
    set_byte(3, 8'($urandom));
    req = 4'b1000;
    serve(int'($urandom_range(2, 10)));
    set_byte(1, 8'($urandom));
    req = 4'b0010;
    serve(int'($urandom_range(2, 10)));
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    model_ptr = 0;
    for (int k = 0; k < NREQ; k++) set_byte(k, 8'($urandom));
    req = 4'b1111;
    serve(int'($urandom_range(2, 10)));
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL first_after_reset: id=%0d want 0", grant_id); end
    req = '0;
  endtask

  task automatic test_gap0();
    logic [7:0] b0, b1, b2;
    int d;
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    z_req_data = {8'h00, b2, b1, b0};
    z_req = 4'b0011;
    tick();
    n_checks++; if (z_gnt !== 4'b0001 || z_tx_start !== 1'b1 || z_tx_data !== b0) begin n_fail++; $display("FAIL z_grant0: gnt=%b start=%b data=%h want 0001/1/%h", z_gnt, z_tx_start, z_tx_data, b0); end
    z_req = 4'b0010;
    tick();
    d = int'($urandom_range(2, 6));
    repeat (d - 2) tick();
    z_tx_done = 1'b1;
    tick();
    z_tx_done = 1'b0;
    n_checks++; if (z_busy !== 1'b0 || z_err !== 1'b0 || z_gnt !== 4'b0000) begin n_fail++; $display("FAIL z_done_idle: busy=%b err=%b gnt=%b want 0/0/0000", z_busy, z_err, z_gnt); end
    tick();
    n_checks++; if (z_gnt !== 4'b0010 || z_tx_start !== 1'b1 || z_grant_id !== 2'd1 || z_tx_data !== b1) begin
      n_fail++; $display("FAIL z_back_to_back: gnt=%b start=%b id=%0d data=%h want 0010/1/1/%h", z_gnt, z_tx_start, z_grant_id, z_tx_data, b1); end
    z_req = '0;
    tick();
    repeat (ZTMO - 1) tick();
    n_checks++; if (z_err !== 1'b0 || z_busy !== 1'b1) begin n_fail++; $display("FAIL z_pre_edge: err=%b busy=%b want 0/1", z_err, z_busy); end
    z_tx_done = 1'b1;
    tick();
    z_tx_done = 1'b0;
    n_checks++; if (z_err !== 1'b0 || z_busy !== 1'b0) begin n_fail++; $display("FAIL z_done_at_timeout: err=%b busy=%b want 0/0", z_err, z_busy); end
    tick();
    n_checks++; if (z_err !== 1'b0) begin n_fail++; $display("FAIL z_no_late_err: err=%b want 0", z_err); end
    z_req = 4'b0100;
    tick();
    n_checks++; if (z_gnt !== 4'b0100 || z_tx_data !== b2) begin n_fail++; $display("FAIL z_grant2: gnt=%b data=%h want 0100/%h", z_gnt, z_tx_data, b2); end
    z_req = '0;
    tick();
    repeat (ZTMO - 1) tick();
    n_checks++; if (z_err !== 1'b0) begin n_fail++; $display("FAIL z_early_err: err=%b want 0", z_err); end
    tick();
    n_checks++; if (z_err !== 1'b1 || z_busy !== 1'b0) begin n_fail++; $display("FAIL z_timeout: err=%b busy=%b want 1/0", z_err, z_busy); end
    tick();
    n_checks++; if (z_err !== 1'b0) begin n_fail++; $display("FAIL z_err_width: err=%b want 0", z_err); end
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) exp_bytes[k] = 8'h00;
    test_reset();
    test_all_requests();
    test_single();
    test_fairness();
    test_timeout();
    test_random();
    test_reset_mid_wait();
    test_gap0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares a single uart_tx serializer among NREQ byte producers using round-robin arbitration.
- Captures the winning requester's byte and issues a one-cycle start to the serializer.
- Waits for the serializer's done, then enforces a programmable inter-frame idle gap before the next grant.
- A watchdog aborts a frame whose done never arrives and flags the error.
- Sits between on-chip byte sources and the uart_tx instance; tx_data/tx_start/tx_done connect to the serializer's a/star/done.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must be ≥ clog2(NREQ).
- GAP_CYCLES, 2, idle cycles between end of one frame and the next arbitration (0 allowed).
- TIMEOUT, 64, maximum WAIT cycles for tx_done before abort (≥2).

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rst_n  input  1  reset; synchronous, active-low.
- req  input  NREQ  per-requester request level; held until that requester's gnt bit pulses.
- req_data  input  8*NREQ  byte of requester k on bits [8k+7:8k]; stable while req[k]=1.
- gnt  output  NREQ  one-hot, one-cycle acceptance pulse.
- grant_id  output  ID_W  index of the current/last granted requester.
- tx_data  output  8  byte to serializer; held stable from SEND through the end of WAIT.
- tx_start  output  1  one-cycle start pulse to serializer.
- tx_done  input  1  serializer frame-complete indication; sampled only in WAIT.
- busy  output  1  high in any state other than IDLE.
- err_timeout  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- All outputs are registered.
- Reset values, applied when i_rst_n=0 at a rising edge:
  - state=IDLE, gnt=0, grant_id=0, tx_data=0, tx_start=0, busy=0, err_timeout=0, counters=0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
- IDLE:
  - If |req, select the first set bit searching from index ptr upward with wrap-around modulo NREQ.
  - On that edge: latch req_data byte into tx_data, grant_id<=k, gnt<=one-hot(k), tx_start<=1, busy<=1; go to SEND.
  - If no request, stay in IDLE with all pulses 0.
- SEND (exactly one cycle): gnt and tx_start are high during this cycle.
  - Next edge: gnt<=0, tx_start<=0, ptr<=(k+1) mod NREQ, wait counter<=0; go to WAIT.
- WAIT:
  - tx_done=1 → go to GAP, or to IDLE if GAP_CYCLES=0.
  - Else if counter==TIMEOUT-1 → err_timeout<=1 for one cycle; go to GAP (or IDLE). Aborted byte is not retried.
  - Else counter increments.
  - tx_done and timeout on the same edge: done wins, no err_timeout.
- GAP: count GAP_CYCLES cycles with busy=1, then go to IDLE. Requests are not evaluated during GAP.
- Latency:
  - req asserted in IDLE at edge N → gnt/tx_start high in cycle N..N+1.
  - Earliest next grant is GAP_CYCLES+1 cycles after the edge sampling tx_done.
- tx_done outside WAIT is ignored.
- req[k] dropping before its grant is simply not served; no memory of past requests.
- Pointer advances only on grant, never on timeout alone. A continuously-asserting requester cannot starve others: service order rotates.
- Synchronous reset in any state (including mid-WAIT) returns to IDLE next edge.
  - No pending gnt pulse survives reset; tx_start is never emitted after reset is sampled.
  - ptr resets to 0.
- grant_id retains its value after the frame until the next grant.

Test Plan:
- Single request: req=4'b0100, byte 8'h0B; tx_done pulsed 10 cycles after tx_start. Expect:
  - gnt=4'b0100 for exactly 1 cycle, coincident with tx_start=1; tx_data=8'h0B stable until done; grant_id=2.
  - busy falls GAP_CYCLES+1 cycles after done.
- Simultaneous requests: req=4'b1111 held, each requester dropping its req after its gnt. Expect:
  - grants in order 0,1,2,3, each separated by done+GAP.
  - tx_data sequence matches the per-requester bytes (e.g. 11,22,33,44).
- Fairness: req0 held permanently plus req2 held.
  - Expect alternating grants 0,2,0,2; never two consecutive grants to 0 while req2=1.
- Timeout: grant issued, tx_done held 0.
  - Expect err_timeout single pulse exactly TIMEOUT cycles after entering WAIT; state returns to IDLE after the gap; next requester served.
- Reset mid-WAIT: i_rst_n=0 for one edge at WAIT cycle 5. Expect:
  - all outputs zero next cycle; a later tx_done is ignored; a subsequent req3 alone is granted normally.
  - With all requests asserted after reset, requester 0 is granted first.
- GAP_CYCLES=0 build: back-to-back requests give next tx_start one cycle after the edge sampling tx_done.
  - Done coinciding with the timeout edge → no err_timeout.
